router_pkt_fifo: RTL

Parametrised packet-aware FIFO: next-generation output buffer between the router synchroniser/FSM and each destination port. Stores DATA_W-bit bytes tagged with a header bit, tracks the remaining bytes of the packet currently being read, and exposes occupancy, almost-full and end-of-packet status so the router FSM can back-pressure early and release the port cleanly.

---
 rtl/router_pkt_fifo.sv | 126 ++++++++++++
 1 files changed

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_pkt_fifo                                                 |
// | Function : packet-aware output FIFO with header tagging, per-packet byte   |
// |            countdown, occupancy/almost-full status and end-of-packet pulse.|
// | Option   : define ROUTER_FIFO_ERR_EN for sticky overflow/underflow err.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module router_pkt_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       soft_reset,
   input  logic                       write_enb,
   input  logic                       read_enb,
   input  logic                       lfd_state,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     level,
   output logic [DATA_W-2:0]          pkt_remaining,
   output logic                       pkt_done,
   output logic                       err
);

   localparam int                 c_AW        = $clog2(DEPTH);
   localparam logic [c_AW:0]      c_AF_THRESH = (c_AW + 1)'(AF_THRESH);
   localparam logic [c_AW:0]      c_PTR_ONE   = (c_AW + 1)'(1);
   localparam logic [DATA_W-2:0]  c_REM_ONE   = (DATA_W - 1)'(1);

   logic [DATA_W:0]      r_mem [DEPTH];
   logic [c_AW:0]        r_wr_ptr;
   logic [c_AW:0]        r_rd_ptr;
   logic                 r_lfd_q;
   logic [DATA_W-1:0]    r_data_out;
   logic [DATA_W-2:0]    r_pkt_remaining;
   logic                 r_pkt_done;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_wr_accept;
   logic                 w_rd_accept;
   logic [DATA_W:0]      w_rd_entry;
   logic [DATA_W-2:0]    w_hdr_count;
   logic [c_AW:0]        w_level;

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_wr_accept = write_enb && !w_full;
   assign w_rd_accept = read_enb && !w_empty;
   assign w_level     = r_wr_ptr - r_rd_ptr;
   assign w_rd_entry  = r_mem[r_rd_ptr[c_AW-1:0]];
   // Header length plus the trailing parity byte.
   assign w_hdr_count = {1'b0, w_rd_entry[DATA_W-1:2]} + c_REM_ONE;

   always_ff @(posedge clock) begin
      if (w_wr_accept) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= {r_lfd_q, data_in};
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_lfd_q <= 1'b0;
      end else begin
         r_lfd_q <= lfd_state;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_data_out      <= '0;
         r_pkt_remaining <= '0;
         r_pkt_done      <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_rd_accept) begin
            r_data_out <= w_rd_entry[DATA_W-1:0];
            r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
            if (w_rd_entry[DATA_W]) begin
               r_pkt_remaining <= w_hdr_count;
            end else if (r_pkt_remaining != '0) begin
               r_pkt_remaining <= r_pkt_remaining - c_REM_ONE;
               r_pkt_done      <= (r_pkt_remaining == c_REM_ONE);
            end
         end
      end
   end

`ifdef ROUTER_FIFO_ERR_EN
   logic r_err;

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         r_err <= 1'b0;
      end else if ((write_enb && w_full) || (read_enb && w_empty)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign data_out      = r_data_out;
   assign empty         = w_empty;
   assign full          = w_full;
   assign almost_full   = (w_level >= c_AF_THRESH);
   assign level         = w_level;
   assign pkt_remaining = r_pkt_remaining;
   assign pkt_done      = r_pkt_done;

endmodule
`default_nettype wire
